// File: rtl/key_word_xform_pkg.sv
// Shared types and constants for the AES key-expansion word transform (package aes_kx_pkg).
// Holds the FSM state encoding, the Rcon start value and polynomial, and xtime().
package aes_kx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } kx_state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_word_xform_if.sv
// Word-in / word-out bus of key_word_xform.
// Both directions use valid/ready: a transfer happens on the rising clk edge where valid
// and ready are both high; the sender holds its payload stable while valid is high.
interface key_word_xform_if;
  logic        in_valid;
  logic        in_ready;
  logic        is_h;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;

  modport master (
    output in_valid, is_h, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, is_h, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/key_word_xform_sbox.sv
// Combinational AES forward S-box (module aes_sbox_lut).
// The table is packed with entry 0 in the top byte, so entry n sits at byte (255 - n).
module aes_sbox_lut (
  input  logic [7:0] plain,
  output logic [7:0] subst
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = TABLE[{~plain, 3'b000} +: 8];
endmodule

// File: rtl/key_word_xform.sv
// AES key-schedule word transform: g (RotWord, SubWord, Rcon XOR) or h (SubWord only),
// SBOX_LANES bytes per cycle. Define KWX_H_FUNC_EN to honour is_h; otherwise every word is g.
module key_word_xform
  import aes_kx_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_start,
  key_word_xform_if.slave        bus,
  output logic [7:0]             rcon,
  output logic                   busy,
  output kx_state_e              state
);

  kx_state_e   state_q, state_n;
  logic [31:0] word_q;
  logic [1:0]  lane_q;
  logic [7:0]  rcon_q;
  logic        h_q;
  logic        h_eff;
  logic        accept;
  logic        last_lane;
  logic [31:0] sub_word;
  logic [31:0] final_word;
  logic [1:0]  lane_idx [SBOX_LANES];
  logic [7:0]  sb_in    [SBOX_LANES];
  logic [7:0]  sb_out   [SBOX_LANES];

`ifdef KWX_H_FUNC_EN
  assign h_eff = bus.is_h;
`else
  logic unused_is_h;
  assign unused_is_h = bus.is_h;
  assign h_eff       = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  assign last_lane = (lane_q == 2'(4 - SBOX_LANES));

  // Byte n of the word lives at bits [31-8n -: 8], i.e. offset {~n, 3'b000}.
  for (genvar k = 0; k < SBOX_LANES; k++) begin : g_lane
    assign lane_idx[k] = lane_q + 2'(k);
    assign sb_in[k]    = word_q[{~lane_idx[k], 3'b000} +: 8];
    aes_sbox_lut u_sbox (
      .plain (sb_in[k]),
      .subst (sb_out[k])
    );
  end

  always_comb begin
    sub_word = word_q;
    for (int k = 0; k < SBOX_LANES; k++) begin
      sub_word[{~lane_idx[k], 3'b000} +: 8] = sb_out[k];
    end
    final_word = h_q ? sub_word : (sub_word ^ {rcon_q, 24'h000000});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_n = ST_SUB;
      ST_SUB:  if (last_lane) state_n = ST_DONE;
      ST_DONE: if (bus.out_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 32'h0;
      lane_q <= 2'd0;
      rcon_q <= RCON_INIT;
      h_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_start) rcon_q <= RCON_INIT;
          if (accept) begin
            word_q <= h_eff ? bus.data_in : {bus.data_in[23:0], bus.data_in[31:24]};
            lane_q <= 2'd0;
            h_q    <= h_eff;
          end
        end
        ST_SUB: begin
          lane_q <= lane_q + 2'(SBOX_LANES);
          if (last_lane) begin
            word_q <= final_word;
            if (!h_q) rcon_q <= xtime(rcon_q);
          end else begin
            word_q <= sub_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.data_out  = word_q;
  assign busy          = (state_q != ST_IDLE);
  assign rcon          = rcon_q;
  assign state         = state_q;

endmodule

// File: doc/key_word_xform.md
KEY_WORD_XFORM -- requirements
Module: key_word_xform

Interface
REQ-001 Parameter SBOX_LANES, default 4, number of parallel S-box lanes; legal values 1, 2, 4.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 key_start  in  1  reloads the round constant (Rcon) to 0x01 for a new key schedule.
REQ-005 in_valid  in  1  input word valid.
REQ-006 in_ready  out  1  block can accept a word; high only in IDLE.
REQ-007 is_h  in  1  sampled with the word; 1 selects the h-transform (SubWord only), 0 selects the g-transform.
REQ-008 data_in  in  32  key word; [31:24] is byte 0, using FIPS-197 ordering.
REQ-009 out_valid  out  1  data_out holds a result.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 data_out  out  32  transformed word.
REQ-012 rcon  out  8  Rcon value the next g-transform will use.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, SUB and DONE, with encodings held in the shared package.
REQ-015 IDLE -> SUB on in_valid && in_ready; on that edge the block latches data_in (rotated as {data_in[23:0], data_in[31:24]} when is_h=0, unrotated when is_h=1) and clears the lane counter.
REQ-016 In SUB, each cycle substitutes SBOX_LANES bytes, lowest byte index first, and increments the lane counter by SBOX_LANES.
REQ-017 SUB -> DONE on the edge completing byte 3; latency from the acceptance edge to out_valid=1 is 4/SBOX_LANES cycles.
REQ-018 On the SUB->DONE edge with is_h=0, the block XORs byte [31:24] with rcon and advances rcon to xtime(rcon): shift left 1, XOR 0x1B if bit 7 was set.
REQ-019 With is_h=1, no Rcon XOR is applied and rcon is not advanced.
REQ-020 DONE holds data_out and out_valid stable until out_ready=1; DONE -> IDLE on out_valid && out_ready.
REQ-021 in_valid in any non-IDLE state is ignored, with no side effects.
REQ-022 key_start in IDLE sets rcon to 0x01; if in_valid is asserted in the same cycle, the accepted word uses 0x01.
REQ-023 key_start outside IDLE is ignored.
REQ-024 rcon does not wrap: the sequence 01,02,04,08,10,20,40,80,1B,36 continues by xtime (6C, D8, ...).
REQ-025 data_out SHALL be valid only while out_valid=1; its value in other states is held, not defined.

Reset
REQ-026 Reset asserted SHALL force: state IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, rcon=0x01, lane counter=0.
REQ-027 Reset mid-operation (in SUB or DONE) SHALL abandon the word; no out_valid pulse follows.
REQ-028 The first acceptance after reset deassertion SHALL be possible in the cycle after the edge where reset is low.

Configuration
REQ-029 Macro KWX_H_FUNC_EN defined: is_h is honoured as in REQ-007, REQ-015 and REQ-019 (AES-256 support).
REQ-030 Macro KWX_H_FUNC_EN undefined: the is_h port remains but is treated as 0; every word is g-transformed.

Structure
REQ-031 Package aes_kx_pkg SHALL hold: the state enum typedef, RCON_INIT=0x01, RCON_POLY=0x1B, and the xtime function.
REQ-032 A combinational sub-module aes_sbox_lut (8-bit in, 8-bit out, forward S-box table) SHALL be instantiated SBOX_LANES times.
REQ-033 The lane byte-select mux SHALL index by the lane counter.

Verification
REQ-034 SBOX_LANES=4, key_start, data_in=0x09CF4F3C, is_h=0 -> data_out=0x8B84EB01 one cycle after acceptance; rcon becomes 0x02.
REQ-035 Follow-on word 0x2A6C7605 with no key_start -> data_out=0x52386BE5; rcon becomes 0x04.
REQ-036 Eleven g-transforms after key_start -> rcon observed 01,02,04,08,10,20,40,80,1B,36,6C; is_h=1, data_in=0x00000000 -> 0x63636363 with rcon unchanged (KWX_H_FUNC_EN defined); same input without the macro -> 0x62636363.
REQ-037 SBOX_LANES=1 -> out_valid exactly 4 cycles after acceptance; with out_ready=0 for 5 cycles, data_out stays stable and in_ready stays 0.
REQ-038 Reset pulse in SUB -> outputs at reset values, no out_valid pulse; the next word after reset uses rcon=0x01.
